// File: rtl/apb_timer_if.sv
// APB bus bundle between the Wishbone-to-APB bridge (master) and the timer (slave).
interface apb_timer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit up-counter with compare match, auto-reload and level irq.
// Every transfer is answered with one wait state via a two-state bus FSM.
module apb_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  apb_timer_if.slave apb,
  output logic     irq_o
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic                  en_q, en_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d;
  logic [7:0]            ps_q, ps_d, pre_q, pre_d;
  logic [DATA_WIDTH-1:0] count_q, count_d, cmp_q, cmp_d;
  logic [DATA_WIDTH-1:0] read_mux, rdata_d;
  logic                  ready_d, slverr_d, access, dec_err, tick, hit;
  logic                  wr_ctrl, wr_count, wr_cmp, wr_status;
  logic [1:0]            reg_sel;

  assign reg_sel = apb.PADDR[3:2];
  assign dec_err = (apb.PADDR[1:0] != 2'b00) || (apb.PADDR[ADDR_WIDTH-1:4] != '0);

  always_comb begin
    read_mux = '0;
    case (reg_sel)
      2'd0: read_mux = {16'h0000, ps_q, 5'b00000, ie_q, ar_q, en_q};
      2'd1: read_mux = count_q;
      2'd2: read_mux = cmp_q;
      2'd3: read_mux = {{(DATA_WIDTH-1){1'b0}}, match_q};
      default: read_mux = '0;
    endcase
  end

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    access   = 1'b0;
    ready_d  = 1'b0;
    slverr_d = 1'b0;
    rdata_d  = apb.PRDATA;
    case (state_q)
      S_IDLE: begin
        if (apb.PSELx && apb.PENABLE) begin
          access   = 1'b1;
          ready_d  = 1'b1;
          slverr_d = dec_err;
          rdata_d  = (!apb.PWRITE && !dec_err) ? read_mux : '0;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ctrl   = access && apb.PWRITE && !dec_err && (reg_sel == 2'd0);
  assign wr_count  = access && apb.PWRITE && !dec_err && (reg_sel == 2'd1);
  assign wr_cmp    = access && apb.PWRITE && !dec_err && (reg_sel == 2'd2);
  assign wr_status = access && apb.PWRITE && !dec_err && (reg_sel == 2'd3);

  assign tick = en_q && (pre_q == ps_q);
  assign hit  = (count_q == cmp_q);

  // Tick effects are applied first so that bus writes override them; the
  // match set is applied after the W1C so that a coinciding set wins.
  always_comb begin
    en_d    = en_q;
    ar_d    = ar_q;
    ie_d    = ie_q;
    ps_d    = ps_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    pre_d   = (!en_q || tick) ? 8'd0 : pre_q + 8'd1;

    if (wr_status && apb.PWDATA[0]) match_d = 1'b0;

    if (tick) begin
      if (hit) begin
        match_d = 1'b1;
        if (ar_q) count_d = '0;
        else      en_d    = 1'b0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end

    if (wr_ctrl) begin
      en_d  = apb.PWDATA[0];
      ar_d  = apb.PWDATA[1];
      ie_d  = apb.PWDATA[2];
      ps_d  = apb.PWDATA[15:8];
      pre_d = 8'd0;
    end
    if (wr_count) count_d = apb.PWDATA;
    if (wr_cmp)   cmp_d   = apb.PWDATA;
  end

  // NOTE: sequential state uses non-blocking assignments only; the reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      apb.PREADY  <= 1'b0;
      apb.PRDATA  <= '0;
      apb.PSLVERR <= 1'b0;
      irq_o       <= 1'b0;
      en_q        <= 1'b0;
      ar_q        <= 1'b0;
      ie_q        <= 1'b0;
      ps_q        <= 8'd0;
      pre_q       <= 8'd0;
      count_q     <= '0;
      cmp_q       <= '1;
      match_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      apb.PREADY  <= ready_d;
      apb.PRDATA  <= rdata_d;
      apb.PSLVERR <= slverr_d;
      irq_o       <= match_d & ie_d;
      en_q        <= en_d;
      ar_q        <= ar_d;
      ie_q        <= ie_d;
      ps_q        <= ps_d;
      pre_q       <= pre_d;
      count_q     <= count_d;
      cmp_q       <= cmp_d;
      match_q     <= match_d;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Randomized and directed bench for apb_timer, checked every cycle against a behavioural model.
module tb_apb_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  apb_timer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_timer #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .apb   (bus.slave),
    .irq_o (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain values; the tick schedule is derived
  // from the number of cycles elapsed since the last CTRL write.
  logic        m_en, m_ar, m_ie, m_match, m_busy;
  logic [7:0]  m_ps;
  logic [31:0] m_count, m_cmp;
  int          m_phase;
  logic        exp_ready, exp_err, exp_irq;
  logic [31:0] exp_rdata;

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return {16'h0, m_ps, 5'b0, m_ie, m_ar, m_en};
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'b0, m_match};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_en = 0; m_ar = 0; m_ie = 0; m_ps = 0; m_match = 0; m_busy = 0;
      m_count = 0; m_cmp = 32'hFFFF_FFFF; m_phase = 0;
      exp_ready = 0; exp_err = 0; exp_irq = 0; exp_rdata = 0;
    end else begin
      automatic bit          acc  = !m_busy && bus.PSELx && bus.PENABLE;
      automatic bit          err  = (bus.PADDR[1:0] != 0) || ((bus.PADDR >> 4) != 0);
      automatic bit          wr   = acc && bus.PWRITE && !err;
      automatic logic [1:0]  sel  = bus.PADDR[3:2];
      automatic bit          tick = m_en && ((m_phase % (int'(m_ps) + 1)) == int'(m_ps));
      automatic bit          hit  = (m_count == m_cmp);
      automatic logic [31:0] rd   = model_read(sel);

      m_phase++;
      if (wr && sel == 3 && bus.PWDATA[0]) m_match = 0;
      if (tick && hit) begin
        m_match = 1;
        if (m_ar) m_count = 0; else m_en = 0;
      end else if (tick) begin
        m_count = m_count + 1;
      end
      if (wr && sel == 0) begin
        {m_ie, m_ar, m_en} = bus.PWDATA[2:0];
        m_ps    = bus.PWDATA[15:8];
        m_phase = 0;
      end
      if (wr && sel == 1) m_count = bus.PWDATA;
      if (wr && sel == 2) m_cmp   = bus.PWDATA;

      exp_ready = acc;
      exp_err   = acc && err;
      if (acc) exp_rdata = (!bus.PWRITE && !err) ? rd : 32'h0;
      m_busy    = acc;
      exp_irq   = m_match && m_ie;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("PREADY",  {31'b0, bus.PREADY},  {31'b0, exp_ready});
      check("PSLVERR", {31'b0, bus.PSLVERR}, {31'b0, exp_err});
      check("PRDATA",  bus.PRDATA,           exp_rdata);
      check("irq_o",   {31'b0, irq},         {31'b0, exp_irq});
    end
  end

  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     output logic [31:0] rdata, output logic err);
    int waits = 0;
    @(negedge clk);
    bus.PSELx = 1; bus.PENABLE = 0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data;
    @(negedge clk);
    bus.PENABLE = 1;
    do begin
      @(negedge clk);
      waits++;
    end while (!bus.PREADY && waits < 6);
    check("ready_latency", waits, 1);
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    bus.PSELx = 0; bus.PENABLE = 0;
  endtask

  task automatic wr_reg(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd; logic e;
    apb(1'b1, addr, data, rd, e);
  endtask

  task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd; logic e;
    apb(1'b0, addr, 32'h0, rd, e);
    check(name, rd, exp);
    check({name, "_err"}, {31'b0, e}, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    bit          seen;

    bus.PSELx = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;

    // Reset values
    rd_expect("rst_ctrl",   32'h0, 32'h0000_0000);
    rd_expect("rst_count",  32'h4, 32'h0000_0000);
    rd_expect("rst_cmp",    32'h8, 32'hFFFF_FFFF);
    rd_expect("rst_status", 32'hC, 32'h0000_0000);

    // Periodic auto-reload with interrupt
    wr_reg(32'h8, 32'd5);
    wr_reg(32'h0, 32'h7);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (irq) seen = 1;
    end
    check("irq_rise", {31'b0, seen}, 32'h1);
    rd_expect("ar_status", 32'hC, 32'h1);
    wr_reg(32'h0, 32'h0);
    wr_reg(32'hC, 32'h1);
    rd_expect("ar_cleared", 32'hC, 32'h0);

    // One-shot with prescale 3
    wr_reg(32'h4, 32'h0);
    wr_reg(32'h8, 32'd2);
    wr_reg(32'h0, 32'h0301);
    idle(30);
    rd_expect("os_count", 32'h4, 32'd2);
    rd_expect("os_ctrl",  32'h0, 32'h0300);
    check("os_irq", {31'b0, irq}, 32'h0);
    rd_expect("os_status", 32'hC, 32'h1);
    wr_reg(32'hC, 32'h1);

    // Wrap through zero
    wr_reg(32'h4, 32'hFFFF_FFFF);
    wr_reg(32'h8, 32'd3);
    wr_reg(32'h0, 32'h1);
    idle(15);
    rd_expect("wrap_count",  32'h4, 32'd3);
    rd_expect("wrap_status", 32'hC, 32'h1);

    // Decode errors
    apb(1'b1, 32'h10, 32'h5, rd, e);
    check("err10_slverr", {31'b0, e}, 32'h1);
    check("err10_rdata",  rd, 32'h0);
    apb(1'b0, 32'h2, 32'h0, rd, e);
    check("err2_slverr", {31'b0, e}, 32'h1);
    check("err2_rdata",  rd, 32'h0);
    rd_expect("err_ctrl_kept", 32'h0, 32'h0);
    rd_expect("err_cmp_kept",  32'h8, 32'd3);

    // W1C colliding with a match tick every cycle
    wr_reg(32'h8, 32'h0);
    wr_reg(32'h4, 32'h0);
    wr_reg(32'h0, 32'h3);
    idle(2);
    wr_reg(32'hC, 32'h1);
    rd_expect("collide_status", 32'hC, 32'h1);
    wr_reg(32'h0, 32'h0);

    // Reset during the access cycle of a COUNT write
    @(negedge clk);
    bus.PSELx = 1; bus.PENABLE = 0; bus.PWRITE = 1; bus.PADDR = 32'h4; bus.PWDATA = 32'h55;
    @(negedge clk);
    bus.PENABLE = 1; rst = 1;
    @(negedge clk);
    bus.PSELx = 0; bus.PENABLE = 0; rst = 0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.PREADY) seen = 1;
    end
    check("rst_no_ready", {31'b0, seen}, 32'h0);
    rd_expect("rst_mid_count", 32'h4, 32'h0);
    rd_expect("rst_mid_cmp",   32'h8, 32'hFFFF_FFFF);

    // Randomized traffic, checked cycle by cycle by the model
    for (int i = 0; i < 120; i++) begin
      automatic logic [31:0] addr = {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      automatic logic [31:0] data;
      if ($urandom_range(0, 7) == 0) addr = $urandom_range(0, 1) ? (addr | 32'h1) : (addr | 32'h40);
      case (addr[3:2])
        2'd0: data = ($urandom & 32'hFFFF_00FF) | (32'($urandom_range(0, 3)) << 8);
        2'd1: data = $urandom_range(0, 1) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1))
                                          : 32'($urandom_range(0, 10));
        2'd2: data = 32'($urandom_range(0, 12));
        default: data = $urandom;
      endcase
      apb(1'($urandom_range(0, 1)), addr, data, rd, e);
      idle($urandom_range(0, 8));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
